// File: rtl/sound_seq_if.sv
// Control/status bundle of the tone sequencer.
// master = the side that requests playback, slave = the sequencer.
interface sound_seq_if;
    logic       play;
    logic       abort;
    logic       speaker;
    logic       busy;
    logic [3:0] step;
    logic       done;

    modport master (output play, abort, input speaker, busy, step, done);
    modport slave  (input play, abort, output speaker, busy, step, done);
endinterface

// File: rtl/sound_seq.sv
// Plays a fixed table of square-wave tones, each step lasting STEP_MS,
// with optional GAP_MS silence between steps, looping and retrigger.
module sound_seq #(
    parameter int unsigned             CLK_FREQ   = 100_000_000,
    parameter int unsigned             NUM_STEPS  = 4,
    parameter logic [16*NUM_STEPS-1:0] TONE_TABLE = {16'd440, 16'd2000, 16'd1000, 16'd500},
    parameter int unsigned             STEP_MS    = 500,
    parameter int unsigned             GAP_MS     = 0,
    parameter bit                      LOOP       = 1'b0,
    parameter bit                      RETRIGGER  = 1'b0
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    sound_seq_if.slave io
);

    localparam int unsigned STEP_CYC = CLK_FREQ / 1000 * STEP_MS;
    localparam int unsigned GAP_CYC  = CLK_FREQ / 1000 * GAP_MS;
    localparam int unsigned DUR_MAX  = (STEP_CYC > GAP_CYC) ? STEP_CYC : GAP_CYC;
    localparam int unsigned DW       = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

    // Half-period in cycles of step i; 0 marks a rest.
    function automatic int unsigned half_of(input int unsigned i);
        int unsigned f;
        f = 32'(TONE_TABLE[16*i +: 16]);
        if (f == 0) return 0;
        return ((CLK_FREQ / (2 * f)) > 0) ? (CLK_FREQ / (2 * f)) : 1;
    endfunction

    function automatic int unsigned max_half();
        int unsigned m;
        m = 1;
        for (int unsigned i = 0; i < NUM_STEPS; i++)
            if (half_of(i) > m) m = half_of(i);
        return m;
    endfunction

    localparam int unsigned HALF_MAX = max_half();
    localparam int unsigned TW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam logic [3:0]  LAST     = 4'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    logic [15:0][TW-1:0] half_m1;
    logic [15:0]         rest;

    for (genvar g = 0; g < 16; g++) begin : g_tab
        if (g < NUM_STEPS) begin : g_used
            localparam int unsigned H = half_of(g);
            assign half_m1[g] = (H == 0) ? '0 : TW'(H - 1);
            assign rest[g]    = (H == 0);
        end else begin : g_unused
            assign half_m1[g] = '0;
            assign rest[g]    = 1'b1;
        end
    end

    state_t        state;
    logic [2:0]    sync;
    logic          sync_d;
    logic [1:0]    warm;
    logic [DW-1:0] dur;
    logic [TW-1:0] tcnt;
    logic          speaker_q;
    logic          busy_q;
    logic [3:0]    step_q;
    logic          done_q;
    logic          start_c;
    logic [3:0]    next_step_c;

    // sync_d resets high and only follows once the synchronizer holds real
    // samples, so a play level already high at reset release is not an edge.
    assign start_c     = (warm == 2'd3) && sync[2] && !sync_d;
    assign next_step_c = (step_q == LAST) ? 4'd0 : step_q + 4'd1;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '0;
            sync_d    <= 1'b1;
            warm      <= '0;
            state     <= IDLE;
            dur       <= '0;
            tcnt      <= '0;
            speaker_q <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            sync   <= {sync[1:0], io.play};
            done_q <= 1'b0;
            if (warm != 2'd3) warm <= warm + 2'd1;
            else              sync_d <= sync[2];

            if (io.abort) begin
                state     <= IDLE;
                busy_q    <= 1'b0;
                step_q    <= '0;
                speaker_q <= 1'b0;
                dur       <= '0;
                tcnt      <= '0;
            end else if (start_c && (state == IDLE || RETRIGGER)) begin
                state     <= TONE;
                busy_q    <= 1'b1;
                step_q    <= '0;
                speaker_q <= 1'b0;
                dur       <= '0;
                tcnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    TONE: begin
                        if (dur == DW'(STEP_CYC - 1)) begin
                            dur       <= '0;
                            tcnt      <= '0;
                            speaker_q <= 1'b0;
                            // A one-shot run ends straight after the last tone;
                            // a looping run keeps the gap before wrapping.
                            if (step_q == LAST && !LOOP) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                                step_q <= '0;
                                done_q <= 1'b1;
                            end else if (GAP_CYC != 0) begin
                                state <= GAP;
                            end else begin
                                step_q <= next_step_c;
                            end
                        end else begin
                            dur <= dur + DW'(1);
                            if (rest[step_q]) begin
                                speaker_q <= 1'b0;
                                tcnt      <= '0;
                            end else if (tcnt == half_m1[step_q]) begin
                                speaker_q <= ~speaker_q;
                                tcnt      <= '0;
                            end else begin
                                tcnt <= tcnt + TW'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (dur == DW'(GAP_CYC - 1)) begin
                            dur    <= '0;
                            tcnt   <= '0;
                            state  <= TONE;
                            step_q <= next_step_c;
                        end else begin
                            dur <= dur + DW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign io.speaker = speaker_q;
    assign io.busy    = busy_q;
    assign io.step    = step_q;
    assign io.done    = done_q;

endmodule

// File: tb/tb_sound_seq.sv
// Checks three sequencer variants (one-shot, retrigger, loop) cycle by cycle
// against a timeline model indexed by cycles since the start edge.
module tb_sound_seq;

    localparam int unsigned CLK    = 10_000;
    localparam int unsigned STEP_C = CLK / 1000 * 10;
    localparam int unsigned GAP_C  = CLK / 1000 * 2;
    localparam int unsigned SLOT   = STEP_C + GAP_C;
    localparam int unsigned NSTEP  = 4;
    localparam int unsigned SEQ    = NSTEP * STEP_C + (NSTEP - 1) * GAP_C;
    localparam int unsigned LOOPN  = NSTEP * SLOT;
    localparam bit [2:0]    M_LOOP = 3'b100;
    localparam bit [2:0]    M_RT   = 3'b010;

    int unsigned freq [4] = '{500, 1000, 0, 250};

    logic clk = 1'b0;
    logic rst_n, play, abort;
    always #5 clk = ~clk;

    sound_seq_if b0 ();
    sound_seq_if b1 ();
    sound_seq_if b2 ();
    assign b0.play = play;  assign b0.abort = abort;
    assign b1.play = play;  assign b1.abort = abort;
    assign b2.play = play;  assign b2.abort = abort;

    sound_seq #(.CLK_FREQ(CLK), .NUM_STEPS(4), .TONE_TABLE({16'd250, 16'd0, 16'd1000, 16'd500}),
                .STEP_MS(10), .GAP_MS(2), .LOOP(1'b0), .RETRIGGER(1'b0))
        u_base (.clk_100MHz(clk), .rst_n(rst_n), .io(b0));
    sound_seq #(.CLK_FREQ(CLK), .NUM_STEPS(4), .TONE_TABLE({16'd250, 16'd0, 16'd1000, 16'd500}),
                .STEP_MS(10), .GAP_MS(2), .LOOP(1'b0), .RETRIGGER(1'b1))
        u_rt (.clk_100MHz(clk), .rst_n(rst_n), .io(b1));
    sound_seq #(.CLK_FREQ(CLK), .NUM_STEPS(4), .TONE_TABLE({16'd250, 16'd0, 16'd1000, 16'd500}),
                .STEP_MS(10), .GAP_MS(2), .LOOP(1'b1), .RETRIGGER(1'b0))
        u_loop (.clk_100MHz(clk), .rst_n(rst_n), .io(b2));

    logic [2:0][6:0] obs;
    assign obs[0] = {b0.speaker, b0.busy, b0.step, b0.done};
    assign obs[1] = {b1.speaker, b1.busy, b1.step, b1.done};
    assign obs[2] = {b2.speaker, b2.busy, b2.step, b2.done};

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          m_active [3];
    bit          m_done [3];
    int unsigned m_t [3];
    int          m_done_cnt [3];
    int          d_cnt [3];
    logic [3:0]  hist;
    int          hist_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] expected(input int k);
        int unsigned slot, r, f;
        logic spk;
        if (!m_active[k]) return {1'b0, 1'b0, 4'd0, m_done[k]};
        slot = m_t[k] / SLOT;
        r    = m_t[k] % SLOT;
        f    = freq[slot];
        spk  = (r < STEP_C && f != 0) ? 1'((r / (CLK / (2 * f))) % 2) : 1'b0;
        return {spk, 1'b1, 4'(slot), 1'b0};
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            m_active[k] = 1'b0;
            m_done[k]   = 1'b0;
            m_t[k]      = 0;
        end
        hist   = '0;
        hist_n = 0;
    endtask

    task automatic model_update(input int k, input logic a, input logic start);
        m_done[k] = 1'b0;
        if (a) begin
            m_active[k] = 1'b0;
        end else if (m_active[k]) begin
            if (start && M_RT[k]) begin
                m_t[k] = 0;
            end else begin
                m_t[k]++;
                if (!M_LOOP[k] && m_t[k] == SEQ) begin
                    m_active[k] = 1'b0;
                    m_done[k]   = 1'b1;
                    m_done_cnt[k]++;
                end else if (M_LOOP[k] && m_t[k] == LOOPN) begin
                    m_t[k] = 0;
                end
            end
        end else if (start) begin
            m_active[k] = 1'b1;
            m_t[k]      = 0;
        end
    endtask

    // One clock: the model consumes the inputs the DUT saw at this edge.
    task automatic tick();
        logic p, a, r, start;
        p = play; a = abort; r = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!r) begin
            reset_model();
        end else begin
            start = (hist_n >= 4) && hist[2] && !hist[3];
            hist  = {hist[2:0], p};
            hist_n++;
            for (int k = 0; k < 3; k++) model_update(k, a, start);
        end
        for (int k = 0; k < 3; k++) begin
            if (obs[k][0] === 1'b1) d_cnt[k]++;
            check($sformatf("out_d%0d", k), 32'(obs[k]), 32'(expected(k)));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_t(input int k, input int unsigned target);
        int budget;
        budget = 3000;
        while (!(m_active[k] && m_t[k] == target) && budget > 0) begin
            tick();
            budget--;
        end
        check($sformatf("reach_t%0d_d%0d", target, k), 32'(m_active[k] && m_t[k] == target), 32'd1);
    endtask

    task automatic pulse_play();
        play = 1'b1; run(1); play = 1'b0;
    endtask

    initial begin
        play = 1'b0; abort = 1'b0; rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin m_done_cnt[k] = 0; d_cnt[k] = 0; end
        reset_model();
        #2;
        for (int k = 0; k < 3; k++) check($sformatf("reset_d%0d", k), 32'(obs[k]), 32'd0);
        run(3);
        rst_n = 1'b1;
        run(8);

        // Basic run from a one-cycle play pulse.
        pulse_play();
        run(520);
        check("basic_done", 32'(d_cnt[0]), 32'd1);

        // Long play level: still a single sequence.
        play = 1'b1; run(2000); play = 1'b0; run(10);
        check("held_done", 32'(d_cnt[0]), 32'd2);

        // Abort mid-run (also ends the looping variant).
        pulse_play();
        run_until_t(0, 149);
        abort = 1'b1; run(1); abort = 1'b0;
        run(500);

        // Second edge during step 2.
        pulse_play();
        run_until_t(0, 250);
        pulse_play();
        run(600);

        // Start edge coinciding with the final-step expiry.
        pulse_play();
        run_until_t(0, SEQ - 4);
        pulse_play();
        run(600);

        // Reset during step 1 with play held high.
        play = 1'b1; run(1);
        run_until_t(0, 130);
        rst_n = 1'b0;
        #1;
        reset_model();
        for (int k = 0; k < 3; k++) check($sformatf("async_rst_d%0d", k), 32'(obs[k]), 32'd0);
        run(3);
        rst_n = 1'b1;
        run(600);
        play = 1'b0; run(3);
        pulse_play();
        run(500);

        // Random play/abort activity.
        repeat (40) begin
            play  = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 15) == 0);
            run($urandom_range(1, 120));
            abort = 1'b0;
            run($urandom_range(0, 3));
        end
        play = 1'b0; abort = 1'b1; run(2); abort = 1'b0; run(10);

        for (int k = 0; k < 3; k++)
            check($sformatf("done_count_d%0d", k), 32'(d_cnt[k]), 32'(m_done_cnt[k]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
